// File: rtl/fsqrt_sched.sv
// fsqrt_sched: round-robin issue and credit-managed writeback scheduler for a shared pipelined Fsqrt
//
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   reqN_valid/ready/x/tag    two requesters (N = 0, 1); ready = grant this cycle
//   sq_x, sq_y                operand to / result from the non-stallable Fsqrt (latency LAT)
//   wb_valid/ready/y/tag/src  buffered result stream, issue order, src = requester index
//   busy                      any op in flight or buffered
module fsqrt_sched #(
    parameter int TAG_W = 5,
    parameter int LAT   = 2,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_x,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_x,
    input  logic [TAG_W-1:0] req1_tag,
    output logic [31:0]      sq_x,
    input  logic [31:0]      sq_y,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [31:0]      wb_y,
    output logic [TAG_W-1:0] wb_tag,
    output logic             wb_src,
    output logic             busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = 32 + TAG_W + 1;

    logic [CW-1:0]    credits, count;
    logic             rr;
    logic [LAT-1:0]   sv;
    logic [TAG_W:0]   smeta [LAT];
    logic [EW-1:0]    mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic             can_issue, g0, g1, grant, push, pop;

    // Only the registered credit count gates issue, so a same-cycle pop cannot unblock it.
    assign can_issue  = rstn && credits != '0;
    assign g0         = can_issue && req0_valid && (!rr || !req1_valid);
    assign g1         = can_issue && req1_valid && (rr || !req0_valid);
    assign grant      = g0 || g1;
    assign req0_ready = g0;
    assign req1_ready = g1;
    assign sq_x       = g0 ? req0_x : g1 ? req1_x : '0;
    assign push       = sv[LAT-1];
    assign wb_valid   = count != '0;
    assign pop        = wb_valid && wb_ready;
    assign {wb_y, wb_tag, wb_src} = wb_valid ? mem[rp] : '0;
    assign busy       = (|sv) || wb_valid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            credits <= CW'(DEPTH);
            rr      <= 1'b0;
            sv      <= '0;
            wp      <= '0;
            rp      <= '0;
            count   <= '0;
        end else begin
            credits <= credits - CW'(grant) + CW'(pop);
            count   <= count + CW'(push) - CW'(pop);
            if (grant)
                rr <= !g1;
            sv[0] <= grant;
            for (int i = 1; i < LAT; i++)
                sv[i] <= sv[i-1];
            if (push)
                wp <= (wp == PW'(DEPTH - 1)) ? '0 : wp + 1'b1;
            if (pop)
                rp <= (rp == PW'(DEPTH - 1)) ? '0 : rp + 1'b1;
        end
    end

    // Metadata and storage need no reset: they are qualified by sv and count.
    always_ff @(posedge clk) begin
        smeta[0] <= {g1 ? req1_tag : req0_tag, g1};
        for (int i = 1; i < LAT; i++)
            smeta[i] <= smeta[i-1];
        if (rstn && push)
            mem[wp] <= {sq_y, smeta[LAT-1]};
    end
endmodule

// File: tb/tb_fsqrt_sched.sv
// tb_fsqrt_sched: randomized and directed checks of fsqrt_sched against a queue-based scoreboard
module tb_fsqrt_sched;
    localparam int TAG_W = 5;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [31:0]      req0_x = '0, req1_x = '0;
    logic [TAG_W-1:0] req0_tag = '0, req1_tag = '0;
    logic [31:0]      sq_x, sq_y;
    logic             wb_valid, wb_src, busy;
    logic             wb_ready = 1'b1;
    logic [31:0]      wb_y;
    logic [TAG_W-1:0] wb_tag;

    fsqrt_sched #(.TAG_W(TAG_W), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_tag(req1_tag),
        .sq_x(sq_x), .sq_y(sq_y),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_y(wb_y), .wb_tag(wb_tag), .wb_src(wb_src),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference single-precision square root for positive normals; specials pass through simply.
    function automatic logic [31:0] fsq(input logic [31:0] x);
        real r;
        int  e;
        if (x[30:23] == 8'h00) return {x[31], 31'b0};
        if (x[31]) return 32'h7fc00000;
        if (x[30:23] == 8'hff) return x;
        r = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        if (e % 2 != 0) begin
            r = r * 2.0;
            e = e - 1;
        end
        r = $sqrt(r);
        e = e / 2 + 127;
        return {1'b0, 8'(e), 23'($rtoi((r - 1.0) * 8388608.0))};
    endfunction

    // Fsqrt datapath stand-in: LAT-cycle pipeline, never stalls, never reset.
    logic [31:0] fp [LAT];
    always @(posedge clk) begin
        fp[0] <= fsq(sq_x);
        for (int i = 1; i < LAT; i++)
            fp[i] <= fp[i-1];
    end
    assign sq_y = fp[LAT-1];

    typedef struct {
        logic [31:0]      y;
        logic [TAG_W-1:0] tag;
        logic             src;
        int               avail;
    } ent_t;

    ent_t q[$];
    logic rr_m = 1'b0;
    logic chk_en = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    // One clock cycle: compare outputs mid-cycle, advance the model, then step past the edge.
    task automatic step();
        logic ok, e0, e1, ev;
        @(negedge clk);
        ok = rstn && q.size() < DEPTH;
        e0 = ok && req0_valid && (!rr_m || !req1_valid);
        e1 = ok && req1_valid && (rr_m || !req0_valid);
        ev = q.size() > 0 && q[0].avail <= cyc;
        if (chk_en) begin
            chk("ready0", {31'b0, req0_ready}, {31'b0, e0});
            chk("ready1", {31'b0, req1_ready}, {31'b0, e1});
            chk("sq_x", sq_x, e0 ? req0_x : e1 ? req1_x : 32'h0);
            chk("wb_valid", {31'b0, wb_valid}, {31'b0, ev});
            chk("wb_y", wb_y, ev ? q[0].y : 32'h0);
            chk("wb_tag", {27'b0, wb_tag}, ev ? {27'b0, q[0].tag} : 32'h0);
            chk("wb_src", {31'b0, wb_src}, ev ? {31'b0, q[0].src} : 32'h0);
            chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
            chk("credits", 32'(dut.credits), 32'(DEPTH - q.size()));
            chk("fifo_ovf", {31'b0, dut.count == DEPTH && dut.push && !dut.pop}, 32'h0);
        end
        if (!rstn) begin
            q.delete();
            rr_m = 1'b0;
        end else begin
            if (ev && wb_ready) void'(q.pop_front());
            if (e0 || e1) begin
                q.push_back('{fsq(e1 ? req1_x : req0_x), e1 ? req1_tag : req0_tag, e1, cyc + LAT + 1});
                rr_m = !e1;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] rnd_x();
        return {1'b0, 8'(100 + $urandom_range(0, 54)), 23'($urandom)};
    endfunction

    initial begin
        // Reset with both requesters asserting.
        rstn = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_x = rnd_x();
        req1_x = rnd_x();
        step();
        chk_en = 1'b1;
        step();
        step();
        rstn = 1'b1;
        step();
        req1_valid = 1'b0;
        req0_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Single op: sqrt(4.0).
        req0_valid = 1'b1;
        req0_x = 32'h40800000;
        req0_tag = 5'd3;
        step();
        req0_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Fairness: both requesters continuously valid.
        for (int k = 0; k < 8; k++) begin
            req0_valid = 1'b1;
            req1_valid = 1'b1;
            req0_x = rnd_x();
            req1_x = rnd_x();
            req0_tag = TAG_W'(2 * k);
            req1_tag = TAG_W'(2 * k + 1);
            step();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Backpressure and credit boundary: credits drain to 0, then pop with a pending request.
        wb_ready = 1'b0;
        req0_valid = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 10) wb_ready = 1'b1;
            req0_x = rnd_x();
            req0_tag = TAG_W'(k);
            step();
        end
        req0_valid = 1'b0;
        for (int i = 0; i < 6; i++) step();

        // Reset mid-flight: stale Fsqrt outputs must not surface.
        req0_valid = 1'b1;
        req0_x = rnd_x();
        step();
        rstn = 1'b0;
        req1_valid = 1'b1;
        req1_x = rnd_x();
        step();
        rstn = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < 7; i++) step();

        // Random traffic with occasional resets and writeback stalls.
        for (int k = 0; k < 500; k++) begin
            rstn = $urandom_range(0, 63) != 0;
            req0_valid = 1'($urandom);
            req1_valid = 1'($urandom);
            req0_x = ($urandom_range(0, 15) == 0) ? $urandom : rnd_x();
            req1_x = rnd_x();
            req0_tag = TAG_W'($urandom);
            req1_tag = TAG_W'($urandom);
            wb_ready = $urandom_range(0, 9) < 7;
            step();
        end
        rstn = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
